mask_edge_detect: RTL and testbench

//  Upstream of the edge-widening stage. Streams a 1-bit foreground mask out of a BRAM,

---
 rtl/mask_edge_detect_if.sv | 23 ++
 rtl/mask_edge_detect.sv | 122 ++++++++++++
 tb/tb_mask_edge_detect.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mask_edge_detect_if.sv
// Bus between the edge detector, the mask BRAM read port and the edge BRAM write port.
// The master side is the detector; the slave side is the surrounding memory/control.
interface mask_edge_detect_if #(
  parameter int ADDR_W = 19
);
  logic              start;
  logic              done;
  logic [ADDR_W-1:0] mask_addr;
  logic              mask_data;
  logic [ADDR_W-1:0] edge_addr;
  logic [2:0]        edge_data;
  logic              edge_we;

  modport master (
    input  start, mask_data,
    output done, mask_addr, edge_addr, edge_data, edge_we
  );

  modport slave (
    output start, mask_data,
    input  done, mask_addr, edge_addr, edge_data, edge_we
  );
endinterface

// File: rtl/mask_edge_detect.sv
// Raster-scans a 1-bit mask BRAM and writes a 3-bit edge code per pixel; a pixel is an
// edge when it is foreground with at least one background 4-neighbour.
module mask_edge_detect #(
  parameter int         WIDTH     = 640,
  parameter int         HEIGHT    = 480,
  parameter int         ADDR_W    = 19,
  parameter int         READ_LAT  = 2,
  parameter logic [2:0] EDGE_CODE = 3'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  mask_edge_detect_if.master bus
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int CW = ADDR_W + 1;
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [ADDR_W-1:0] RD_LAST = ADDR_W'(N - 1);
  localparam logic [CW-1:0]     IN_N    = CW'(N);
  localparam logic [CW-1:0]     IN_LAG  = CW'(WIDTH + 1);
  localparam logic [CW-1:0]     IN_LAST = CW'(N + WIDTH);
  localparam logic [XW-1:0]     X_LAST  = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST  = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   rd_cnt;
  logic [READ_LAT-1:0] rd_vld_p;
  logic [CW-1:0]       in_cnt;
  logic [XW-1:0]       cx;
  logic [YW-1:0]       cy;
  logic                done_r;
  logic                edge_we_r;
  logic [ADDR_W-1:0]   edge_addr_r;
  logic [2:0]          edge_data_r;
  // Two line buffers plus the centre row collapsed into one history: bit j is pixel i-1-j.
  logic [2*WIDTH:0]    win_sr;
  logic                din;
  logic                shift_en;
  logic                interior;

  function automatic logic [2:0] edge_code(input logic c, input logic u, input logic d,
                                           input logic l, input logic r,
                                           input logic interior_f);
    return (interior_f && c && !(u && d && l && r)) ? EDGE_CODE : 3'd0;
  endfunction

  // Returned read data shifts in while valid; during flush zeros are shifted instead.
  assign din      = rd_vld_p[READ_LAT-1] & bus.mask_data;
  assign shift_en = bus.start && (rd_vld_p[READ_LAT-1] || (state == FLUSH && in_cnt >= IN_N));
  assign interior = (cx != '0) && (cx != X_LAST) && (cy != '0) && (cy != Y_LAST);

  always_ff @(posedge clk) begin
    if (shift_en) win_sr <= {win_sr[2*WIDTH-1:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_cnt      <= '0;
      rd_vld_p    <= '0;
      in_cnt      <= '0;
      cx          <= '0;
      cy          <= '0;
      done_r      <= 1'b0;
      edge_we_r   <= 1'b0;
      edge_addr_r <= '0;
      edge_data_r <= '0;
    end else begin
      edge_we_r <= 1'b0;
      if (!bus.start) begin
        state    <= IDLE;
        done_r   <= 1'b0;
        rd_vld_p <= '0;
      end else begin
        rd_vld_p <= {rd_vld_p[READ_LAT-2:0], state == RUN};
        case (state)
          IDLE: begin
            state  <= RUN;
            rd_cnt <= '0;
            in_cnt <= '0;
            cx     <= '0;
            cy     <= '0;
          end
          RUN: begin
            if (rd_cnt == RD_LAST) state <= FLUSH;
            else rd_cnt <= rd_cnt + 1'b1;
          end
          FLUSH: if (shift_en && in_cnt == IN_LAST) state <= DONE;
          DONE:  done_r <= 1'b1;
          default: state <= IDLE;
        endcase
        // Window centre lags the incoming pixel by one row plus one column.
        if (shift_en) begin
          in_cnt <= in_cnt + 1'b1;
          if (in_cnt >= IN_LAG) begin
            edge_we_r   <= 1'b1;
            edge_addr_r <= ADDR_W'(in_cnt - IN_LAG);
            edge_data_r <= edge_code(win_sr[WIDTH], win_sr[2*WIDTH], win_sr[0],
                                     win_sr[WIDTH+1], win_sr[WIDTH-1], interior);
            if (cx == X_LAST) begin
              cx <= '0;
              cy <= cy + 1'b1;
            end else begin
              cx <= cx + 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.done      = done_r;
  assign bus.mask_addr = rd_cnt;
  assign bus.edge_addr = edge_addr_r;
  assign bus.edge_data = edge_data_r;
  assign bus.edge_we   = edge_we_r;

endmodule

// File: tb/tb_mask_edge_detect.sv
// Directed bench for mask_edge_detect on an 8x6 frame with a two-cycle mask BRAM model.
module tb_mask_edge_detect;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int AW = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mask_edge_detect_if #(.ADDR_W(AW)) bus ();

  mask_edge_detect #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .READ_LAT(2), .EDGE_CODE(3'd1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic       mem  [N];
  logic [2:0] expd [N];
  logic       q1, q2;

  always @(posedge clk) begin
    q1 <= mem[bus.mask_addr];
    q2 <= q1;
  end
  assign bus.mask_data = q2;

  int sc2_edges [12] = '{10, 11, 12, 13, 18, 21, 26, 29, 34, 35, 36, 37};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_scene();
    for (int i = 0; i < N; i++) begin
      mem[i]  = 1'b0;
      expd[i] = 3'd0;
    end
  endtask

  task automatic load_block();
    clear_scene();
    for (int y = 1; y <= 4; y++)
      for (int x = 2; x <= 5; x++) mem[y*W + x] = 1'b1;
    for (int j = 0; j < 12; j++) expd[sc2_edges[j]] = 3'd1;
  endtask

  task automatic run_sweep(input string tag);
    int nexp = 0;
    int cyc  = 0;
    bit fin  = 1'b0;
    bus.start = 1'b1;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.edge_we) begin
        check({tag, "_addr"}, 32'(bus.edge_addr), 32'(nexp));
        check({tag, "_data"}, 32'(bus.edge_data), 32'(expd[nexp]));
        nexp++;
        if (nexp == N) begin
          @(negedge clk);
          check({tag, "_done"}, 32'(bus.done), 32'd1);
          check({tag, "_we_after"}, 32'(bus.edge_we), 32'd0);
          fin = 1'b1;
        end
      end else if (nexp > 0) begin
        check({tag, "_contig"}, 32'(bus.edge_we), 32'd1);
      end
    end
    check({tag, "_finished"}, 32'(fin), 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    check({tag, "_done_clr"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    clear_scene();

    // asynchronous reset with no clock edge in between
    #2 rst_n = 1'b0;
    #1;
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_we", 32'(bus.edge_we), 32'd0);
    check("rst_eaddr", 32'(bus.edge_addr), 32'd0);
    check("rst_edata", 32'(bus.edge_data), 32'd0);
    check("rst_maddr", 32'(bus.mask_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: all-zero mask
    clear_scene();
    run_sweep("sc1");

    // 2: solid block x2..5, y1..4
    load_block();
    run_sweep("sc2");

    // 3: single pixel at (3,2)
    clear_scene();
    mem[2*W + 3] = 1'b1;
    expd[19]     = 3'd1;
    run_sweep("sc3");

    // 4: border-only pixels
    clear_scene();
    mem[3*W + 0] = 1'b1;
    mem[5*W + 7] = 1'b1;
    run_sweep("sc4");

    // 5: abort at i=20, then clean restart on the single-pixel mask
    load_block();
    bus.start = 1'b1;
    begin
      int cyc = 0;
      while (bus.mask_addr != AW'(20) && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check("sc5_reach20", 32'(bus.mask_addr), 32'd20);
    end
    check("sc5_we_before", 32'(bus.edge_we), 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    check("sc5_we_abort", 32'(bus.edge_we), 32'd0);
    check("sc5_done_abort", 32'(bus.done), 32'd0);
    @(negedge clk);
    check("sc5_we_idle", 32'(bus.edge_we), 32'd0);
    clear_scene();
    mem[2*W + 3] = 1'b1;
    expd[19]     = 3'd1;
    run_sweep("sc5r");

    // 6: reset mid-run, then sweep a different mask
    load_block();
    bus.start = 1'b1;
    repeat (30) @(negedge clk);
    check("sc6_we_before", 32'(bus.edge_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("sc6_rst_we", 32'(bus.edge_we), 32'd0);
    check("sc6_rst_done", 32'(bus.done), 32'd0);
    check("sc6_rst_maddr", 32'(bus.mask_addr), 32'd0);
    check("sc6_rst_eaddr", 32'(bus.edge_addr), 32'd0);
    check("sc6_rst_edata", 32'(bus.edge_data), 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_scene();
    mem[3*W + 5] = 1'b1;
    expd[29]     = 3'd1;
    run_sweep("sc6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
